hpi_access_sequencer: RTL and testbench

HPI_ACCESS_SEQUENCER -- requirements
Module: hpi_access_sequencer

---
 rtl/hpi_access_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_hpi_access_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpi_access_sequencer.sv
// Two-requester sequencer for the CY7C67200 HPI port: round-robin grant, then
// setup/strobe/hold/recovery timing on registered, glitch-free HPI pins.
module hpi_access_sequencer #(
    parameter int unsigned SETUP_CYC    = 1,
    parameter int unsigned STROBE_CYC   = 4,
    parameter int unsigned HOLD_CYC     = 1,
    parameter int unsigned RECOVERY_CYC = 2,
    parameter int unsigned RESET_CYC    = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset,

    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [1:0]  req0_addr,
    input  logic [15:0] req0_wdata,
    output logic        req0_ready,
    output logic        rsp0_valid,
    output logic [15:0] rsp0_rdata,

    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [1:0]  req1_addr,
    input  logic [15:0] req1_wdata,
    output logic        req1_ready,
    output logic        rsp1_valid,
    output logic [15:0] rsp1_rdata,

    output logic [1:0]  hpi_address,
    output logic        hpi_cs_n,
    output logic        hpi_rd_n,
    output logic        hpi_wr_n,
    output logic        hpi_reset_n,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    input  logic [15:0] hpi_data_in
);

    typedef enum logic [2:0] {
        S_RSTWAIT,
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_RECOVER
    } state_e;

    localparam logic [7:0] RST_LAST = 8'(RESET_CYC - 1);
    localparam logic [7:0] SET_LAST = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STB_LAST = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HLD_LAST = 8'(HOLD_CYC - 1);
    localparam logic [7:0] REC_LAST = 8'(RECOVERY_CYC - 1);

    state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       phase_last;

    logic [1:0]       req_valid;
    logic [1:0]       req_write;
    logic [1:0][1:0]  req_addr;
    logic [1:0][15:0] req_wdata;

    logic gnt_en, gnt_sel;

    logic        last_q;
    logic        gid_q;
    logic        wr_q;
    logic [1:0]  addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdcap_q;

    logic        cur_wr;
    logic [1:0]  cur_addr;
    logic [15:0] cur_wdata;
    logic        active_d;
    logic        rsp_fire;

    logic        cs_n_q, cs_n_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        rstn_q, rstn_d;
    logic        oe_q, oe_d;
    logic [1:0]  haddr_q, haddr_d;
    logic [15:0] hdata_q, hdata_d;
    logic [1:0]       rsp_vld_q, rsp_vld_d;
    logic [1:0][15:0] rsp_rdata_q, rsp_rdata_d;

    assign req_valid = {req1_valid, req0_valid};
    assign req_write = {req1_write, req0_write};
    assign req_addr  = {req1_addr, req0_addr};
    assign req_wdata = {req1_wdata, req0_wdata};

    // On a tie, grant whoever was not granted last; otherwise the lone requester.
    always_comb begin
        gnt_en  = (state_q == S_IDLE) && (|req_valid);
        gnt_sel = (&req_valid) ? ~last_q : req_valid[1];
    end

    assign req0_ready = gnt_en & ~gnt_sel;
    assign req1_ready = gnt_en &  gnt_sel;

    always_comb begin
        case (state_q)
            S_RSTWAIT: phase_last = (cnt_q == RST_LAST);
            S_SETUP:   phase_last = (cnt_q == SET_LAST);
            S_STROBE:  phase_last = (cnt_q == STB_LAST);
            S_HOLD:    phase_last = (cnt_q == HLD_LAST);
            S_RECOVER: phase_last = (cnt_q == REC_LAST);
            default:   phase_last = 1'b0;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= S_RSTWAIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = phase_last ? 8'd0 : cnt_q + 8'd1;
        case (state_q)
            S_RSTWAIT: if (phase_last) state_d = S_IDLE;
            S_IDLE: begin
                cnt_d = '0;
                if (gnt_en) state_d = S_SETUP;
            end
            S_SETUP:   if (phase_last) state_d = S_STROBE;
            S_STROBE:  if (phase_last) state_d = S_HOLD;
            S_HOLD:    if (phase_last) state_d = S_RECOVER;
            S_RECOVER: if (phase_last) state_d = S_IDLE;
            default: begin
                state_d = S_RSTWAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Request capture in the ready cycle; read data latched on the last strobe edge.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            last_q  <= 1'b1;
            gid_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdcap_q <= '0;
        end else begin
            if (gnt_en) begin
                last_q  <= gnt_sel;
                gid_q   <= gnt_sel;
                wr_q    <= req_write[gnt_sel];
                addr_q  <= req_addr[gnt_sel];
                wdata_q <= req_wdata[gnt_sel];
            end
            if (state_q == S_STROBE && phase_last && !wr_q)
                rdcap_q <= hpi_data_in;
        end
    end

    // Pin values are computed from the next state so every HPI output is a flop.
    always_comb begin
        cur_wr    = gnt_en ? req_write[gnt_sel] : wr_q;
        cur_addr  = gnt_en ? req_addr[gnt_sel]  : addr_q;
        cur_wdata = gnt_en ? req_wdata[gnt_sel] : wdata_q;
        active_d  = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);

        cs_n_d  = ~active_d;
        rd_n_d  = ~((state_d == S_STROBE) && !cur_wr);
        wr_n_d  = ~((state_d == S_STROBE) &&  cur_wr);
        oe_d    = active_d && cur_wr;
        rstn_d  = (state_d != S_RSTWAIT);
        haddr_d = (state_d == S_SETUP) ? cur_addr : haddr_q;
        hdata_d = ((state_d == S_SETUP) && cur_wr) ? cur_wdata : hdata_q;

        rsp_fire    = (state_q == S_HOLD) && phase_last;
        rsp_vld_d   = '0;
        rsp_rdata_d = rsp_rdata_q;
        if (rsp_fire) begin
            rsp_vld_d[gid_q] = 1'b1;
            if (!wr_q) rsp_rdata_d[gid_q] = rdcap_q;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            rstn_q      <= 1'b0;
            oe_q        <= 1'b0;
            haddr_q     <= '0;
            hdata_q     <= '0;
            rsp_vld_q   <= '0;
            rsp_rdata_q <= '0;
        end else begin
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            rstn_q      <= rstn_d;
            oe_q        <= oe_d;
            haddr_q     <= haddr_d;
            hdata_q     <= hdata_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign hpi_cs_n     = cs_n_q;
    assign hpi_rd_n     = rd_n_q;
    assign hpi_wr_n     = wr_n_q;
    assign hpi_reset_n  = rstn_q;
    assign hpi_data_oe  = oe_q;
    assign hpi_address  = haddr_q;
    assign hpi_data_out = hdata_q;
    assign rsp0_valid   = rsp_vld_q[0];
    assign rsp1_valid   = rsp_vld_q[1];
    assign rsp0_rdata   = rsp_rdata_q[0];
    assign rsp1_rdata   = rsp_rdata_q[1];

endmodule

// File: tb/tb_hpi_access_sequencer.sv
// Scoreboard bench: default-timing instance plus a retimed instance (2/1/2/1).
module tb_hpi_access_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req0_valid, req0_write, req0_ready, rsp0_valid;
    logic [1:0]  req0_addr;
    logic [15:0] req0_wdata, rsp0_rdata;
    logic        req1_valid, req1_write, req1_ready, rsp1_valid;
    logic [1:0]  req1_addr;
    logic [15:0] req1_wdata, rsp1_rdata;
    logic [1:0]  hpi_address;
    logic        hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_reset_n, hpi_data_oe;
    logic [15:0] hpi_data_out, hpi_data_in;

    logic        b_req0_valid, b_req0_write, b_req0_ready, b_rsp0_valid;
    logic [1:0]  b_req0_addr;
    logic [15:0] b_req0_wdata, b_rsp0_rdata;
    logic        b_req1_valid, b_req1_write, b_req1_ready, b_rsp1_valid;
    logic [1:0]  b_req1_addr;
    logic [15:0] b_req1_wdata, b_rsp1_rdata;
    logic [1:0]  b_hpi_address;
    logic        b_hpi_cs_n, b_hpi_rd_n, b_hpi_wr_n, b_hpi_reset_n, b_hpi_data_oe;
    logic [15:0] b_hpi_data_out, b_hpi_data_in;

    hpi_access_sequencer dut (
        .clk_clk(clk), .reset_reset(rst),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
        .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
        .rsp1_rdata(rsp1_rdata),
        .hpi_address(hpi_address), .hpi_cs_n(hpi_cs_n), .hpi_rd_n(hpi_rd_n),
        .hpi_wr_n(hpi_wr_n), .hpi_reset_n(hpi_reset_n), .hpi_data_out(hpi_data_out),
        .hpi_data_oe(hpi_data_oe), .hpi_data_in(hpi_data_in)
    );

    hpi_access_sequencer #(
        .SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(2), .RECOVERY_CYC(1), .RESET_CYC(16)
    ) dut_b (
        .clk_clk(clk), .reset_reset(rst),
        .req0_valid(b_req0_valid), .req0_write(b_req0_write), .req0_addr(b_req0_addr),
        .req0_wdata(b_req0_wdata), .req0_ready(b_req0_ready), .rsp0_valid(b_rsp0_valid),
        .rsp0_rdata(b_rsp0_rdata),
        .req1_valid(b_req1_valid), .req1_write(b_req1_write), .req1_addr(b_req1_addr),
        .req1_wdata(b_req1_wdata), .req1_ready(b_req1_ready), .rsp1_valid(b_rsp1_valid),
        .rsp1_rdata(b_rsp1_rdata),
        .hpi_address(b_hpi_address), .hpi_cs_n(b_hpi_cs_n), .hpi_rd_n(b_hpi_rd_n),
        .hpi_wr_n(b_hpi_wr_n), .hpi_reset_n(b_hpi_reset_n), .hpi_data_out(b_hpi_data_out),
        .hpi_data_oe(b_hpi_data_oe), .hpi_data_in(b_hpi_data_in)
    );

    typedef struct {
        logic        gid;
        logic [15:0] rdata;
        int          due;
    } rsp_t;

    typedef struct {
        int          at;
        logic [15:0] val;
    } plan_t;

    rsp_t        sb[$];
    plan_t       plan[$];
    rsp_t        mon_e;
    logic [15:0] exp_rdata [2];
    logic [15:0] rd_val;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Expected completion at ready+7; read data presented only in ready+5.
    task automatic sb_push(input logic who, input logic wr, input int t);
        rsp_t  e;
        plan_t p;
        if (!wr) begin
            exp_rdata[who] = rd_val;
            p.at  = t + 5;
            p.val = rd_val;
            plan.push_back(p);
        end
        e.gid   = who;
        e.rdata = exp_rdata[who];
        e.due   = t + 7;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        hpi_data_in = 16'hDEAD;
        if (plan.size() != 0 && plan[0].at == cyc) begin
            hpi_data_in = plan[0].val;
            plan.delete(0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("inv_rd_wr", 32'(hpi_rd_n | hpi_wr_n), 32'd1);
            chk("inv_oe_rd", 32'(hpi_data_oe & ~hpi_rd_n), 32'd0);
            chk("rdy_excl", 32'(req0_ready & req1_ready), 32'd0);
            chk("rdy_in_rstwait", 32'((req0_ready | req1_ready) & ~hpi_reset_n), 32'd0);
            chk("rsp_excl", 32'(rsp0_valid & rsp1_valid), 32'd0);
            chk("b_inv_rd_wr", 32'(b_hpi_rd_n | b_hpi_wr_n), 32'd1);
            chk("b_inv_oe_rd", 32'(b_hpi_data_oe & ~b_hpi_rd_n), 32'd0);
            if (rsp0_valid | rsp1_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'(sb.size()), 32'd1);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_gid", 32'(rsp1_valid), 32'(mon_e.gid));
                    chk("rsp_cycle", 32'(cyc), 32'(mon_e.due));
                    chk("rsp_rdata", 32'(mon_e.gid ? rsp1_rdata : rsp0_rdata), 32'(mon_e.rdata));
                    chk("rsp_other_rdata", 32'(mon_e.gid ? rsp0_rdata : rsp1_rdata),
                        32'(exp_rdata[mon_e.gid ? 0 : 1]));
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_cs_n"}, 32'(hpi_cs_n), 32'd1);
        chk({tag, "_rd_n"}, 32'(hpi_rd_n), 32'd1);
        chk({tag, "_wr_n"}, 32'(hpi_wr_n), 32'd1);
        chk({tag, "_reset_n"}, 32'(hpi_reset_n), 32'd0);
        chk({tag, "_oe"}, 32'(hpi_data_oe), 32'd0);
        chk({tag, "_addr"}, 32'(hpi_address), 32'd0);
        chk({tag, "_dout"}, 32'(hpi_data_out), 32'd0);
        chk({tag, "_ready"}, 32'({req1_ready, req0_ready}), 32'd0);
        chk({tag, "_rsp_valid"}, 32'({rsp1_valid, rsp0_valid}), 32'd0);
        chk({tag, "_rdata"}, {rsp1_rdata, rsp0_rdata}, 32'd0);
    endtask

    task automatic wait_ready(input logic who, output int t);
        t = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if ((who ? req1_ready : req0_ready) === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_any(output logic who, output int t);
        t   = -1;
        who = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                t   = cyc;
                who = req1_ready;
                break;
            end
        end
        if (t < 0) chk("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic txn(input logic who, input logic wr, input logic [1:0] a,
                       input logic [15:0] wd, output int t);
        @(posedge clk); #1;
        if (who) begin
            req1_valid = 1'b1; req1_write = wr; req1_addr = a; req1_wdata = wd;
        end else begin
            req0_valid = 1'b1; req0_write = wr; req0_addr = a; req0_wdata = wd;
        end
        wait_ready(who, t);
        if (t >= 0) sb_push(who, wr, t);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        int   t, t0, c0, tp, j;
        logic who;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 2'd1; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0;   req1_wdata = '0;
        b_req0_valid = 1'b0; b_req0_write = 1'b0; b_req0_addr = '0; b_req0_wdata = '0;
        b_req1_valid = 1'b0; b_req1_write = 1'b0; b_req1_addr = '0; b_req1_wdata = '0;
        b_hpi_data_in = 16'h7E57;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        rd_val = 16'h1357;

        // Power-on: read held through reset, granted only in the first IDLE cycle.
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        c0  = cyc;
        wait_ready(1'b0, t);
        chk("rst_len", 32'(t - c0), 32'd16);
        chk("rstn_at_grant", 32'(hpi_reset_n), 32'd1);
        if (t >= 0) sb_push(1'b0, 1'b0, t);
        @(posedge clk); #1;
        req0_valid = 1'b0;

        // Write: cs_n low 6, wr_n low in cs cycles 2..5, data driven throughout.
        txn(1'b0, 1'b1, 2'd2, 16'h1234, t);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("w_cs_n", 32'(hpi_cs_n), 32'(k > 6));
            chk("w_wr_n", 32'(hpi_wr_n), 32'(k < 2 || k > 5));
            chk("w_rd_n", 32'(hpi_rd_n), 32'd1);
            chk("w_oe", 32'(hpi_data_oe), 32'(k <= 6));
            if (k <= 6) begin
                chk("w_data", 32'(hpi_data_out), 32'h1234);
                chk("w_addr", 32'(hpi_address), 32'd2);
            end
        end

        // Read on requester 1 with the pad valid only in the last strobe cycle.
        rd_val = 16'hBEEF;
        txn(1'b1, 1'b0, 2'd3, 16'h0000, t);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("r_cs_n", 32'(hpi_cs_n), 32'(k > 6));
            chk("r_rd_n", 32'(hpi_rd_n), 32'(k < 2 || k > 5));
            chk("r_wr_n", 32'(hpi_wr_n), 32'd1);
            chk("r_oe", 32'(hpi_data_oe), 32'd0);
            if (k <= 6) chk("r_addr", 32'(hpi_address), 32'd3);
        end

        // Both requesters valid back to back: alternating grants, 9 cycles apart.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 2'd1; req0_wdata = 16'hA5A5;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 2'd0;
        tp = -1;
        for (int i = 0; i < 4; i++) begin
            wait_any(who, t);
            chk("rr_who", 32'(who), 32'(i % 2));
            if (tp >= 0) chk("rr_spacing", 32'(t - tp), 32'd9);
            tp = t;
            rd_val = 16'hC000 + 16'(i);
            if (t >= 0) sb_push(who, ~who, t);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Reset in the middle of a read strobe: abort, then regrant after RSTWAIT.
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 2'd2;
        wait_ready(1'b0, t);
        repeat (3) @(negedge clk);
        chk("abort_in_strobe", 32'(hpi_rd_n), 32'd0);
        rst = 1'b1;
        sb.delete();
        plan.delete();
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        #1;
        check_reset("abort");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        c0  = cyc;
        wait_ready(1'b0, t);
        chk("abort_regrant", 32'(t - c0), 32'd16);
        rd_val = 16'h5A5A;
        if (t >= 0) sb_push(1'b0, 1'b0, t);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        // Retimed instance: rsp at ready+6, next ready at ready+7.
        @(posedge clk); #1;
        b_req0_valid = 1'b1; b_req0_write = 1'b1; b_req0_addr = 2'd1; b_req0_wdata = 16'h0F0F;
        b_req1_valid = 1'b1; b_req1_write = 1'b0; b_req1_addr = 2'd2;
        t0 = -1;
        for (int i = 0; i < 64 && t0 < 0; i++) begin
            @(negedge clk);
            if (b_req0_ready === 1'b1) t0 = cyc;
        end
        if (t0 < 0) chk("b_ready_timeout", 32'd0, 32'd1);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            j = (k > 7) ? k - 7 : k;
            chk("b_cs_n", 32'(b_hpi_cs_n), 32'(!(j >= 1 && j <= 5)));
            chk("b_wr_n", 32'(b_hpi_wr_n), 32'(k != 3));
            chk("b_rd_n", 32'(b_hpi_rd_n), 32'(k != 10));
            chk("b_oe", 32'(b_hpi_data_oe), 32'(k <= 5));
            chk("b_rsp0", 32'(b_rsp0_valid), 32'(k == 6));
            chk("b_rsp1", 32'(b_rsp1_valid), 32'(k == 13));
            chk("b_ready1", 32'(b_req1_ready), 32'(k == 7));
            if (k <= 5) chk("b_wdata", 32'(b_hpi_data_out), 32'h0F0F);
            if (k == 6) chk("b_rdata0", 32'(b_rsp0_rdata), 32'd0);
            if (k == 13) chk("b_rdata1", 32'(b_rsp1_rdata), 32'h7E57);
            if (k == 1) b_req0_valid = 1'b0;
            if (k == 8) b_req1_valid = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
